// File: rtl/resource_driver_if.sv
// Request/command bundle shared by the requesters, the resource_driver and the
// downstream resource counter.
interface resource_driver_if #(
   parameter int ACC_W = 6
);
   logic                    tick;
   logic                    decay_en;
   logic                    gain_req;
   logic                    gain_fast;
   logic                    loss_req;
   logic                    loss_fast;
   logic                    set_req;
   logic                    inc;
   logic                    dec;
   logic                    fast;
   logic                    setval;
   logic signed [ACC_W-1:0] pending;
   logic                    busy;

   modport master (
      output tick, decay_en, gain_req, gain_fast, loss_req, loss_fast, set_req,
      input  inc, dec, fast, setval, pending, busy
   );

   modport slave (
      input  tick, decay_en, gain_req, gain_fast, loss_req, loss_fast, set_req,
      output inc, dec, fast, setval, pending, busy
   );
endinterface

// File: rtl/resource_driver.sv
// Paces asynchronous gain/loss/decay events into one-cycle inc/dec/fast/setval
// commands for a downstream saturating resource counter.
module resource_driver #(
   parameter int ACC_W        = 6,
   parameter int FAST_STEP    = 3,
   parameter int DECAY_PERIOD = 4,
   parameter int GAP          = 1
) (
   input  logic             clk,
   input  logic             rst,
   resource_driver_if.slave bus
);
   localparam int SUM_W = ACC_W + 2;
   localparam int PRE_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic signed [SUM_W-1:0] ZERO_S    = SUM_W'(0);
   localparam logic signed [SUM_W-1:0] ONE_S     = SUM_W'(1);
   localparam logic signed [SUM_W-1:0] FAST_S    = SUM_W'(FAST_STEP);
   localparam logic signed [SUM_W-1:0] ACC_MAX_S = SUM_W'((1 << (ACC_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] ACC_MIN_S = -ACC_MAX_S - ONE_S;
   localparam logic signed [ACC_W-1:0] ACC_ZERO  = ACC_W'(0);
   localparam logic [PRE_W-1:0]        PRE_ZERO  = PRE_W'(0);
   localparam logic [PRE_W-1:0]        PRE_ONE   = PRE_W'(1);
   localparam logic [PRE_W-1:0]        PRE_LAST  = PRE_W'(DECAY_PERIOD - 1);
   localparam logic [GAP_W-1:0]        GAP_ZERO  = GAP_W'(0);
   localparam logic [GAP_W-1:0]        GAP_ONE   = GAP_W'(1);
   localparam logic [GAP_W-1:0]        GAP_LOAD  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t                  state_r, state_s;
   logic signed [ACC_W-1:0] acc_r, acc_s;
   logic [PRE_W-1:0]        presc_r, presc_s;
   logic [GAP_W-1:0]        gap_r, gap_s;
   logic                    inc_r, dec_r, fast_r, setval_r, busy_r;
   logic                    inc_s, dec_s, fast_s, setval_s, busy_s;
   logic                    decay_s;
   logic signed [SUM_W-1:0] acc_ext_s, delta_s, amount_s, sum_s;

   assign acc_ext_s = {{2{acc_r[ACC_W-1]}}, acc_r};
   assign busy_s    = (acc_s != ACC_ZERO) || (state_s == ST_GAP);

   // State register of the issue-pacing FSM and its gap counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         gap_r   <= GAP_ZERO;
      end else begin
         state_r <= state_s;
         gap_r   <= gap_s;
      end
   end

   // Next-state logic: an issue opens a gap window, set_req forces IDLE
   always_comb begin
      state_s = state_r;
      gap_s   = gap_r;
      if (bus.set_req) begin
         state_s = ST_IDLE;
         gap_s   = GAP_ZERO;
      end else begin
         case (state_r)
            ST_IDLE, ST_ISSUE: begin
               if (inc_s || dec_s) begin
                  if (GAP > 0) begin
                     state_s = ST_GAP;
                     gap_s   = GAP_LOAD;
                  end else if (acc_s != ACC_ZERO) begin
                     state_s = ST_ISSUE;
                  end else begin
                     state_s = ST_IDLE;
                  end
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_GAP: begin
               if (gap_r == GAP_ZERO) begin
                  state_s = (acc_r != ACC_ZERO) ? ST_ISSUE : ST_IDLE;
               end else begin
                  gap_s = gap_r - GAP_ONE;
               end
            end
            default: begin
               state_s = ST_IDLE;
               gap_s   = GAP_ZERO;
            end
         endcase
      end
   end

   // Output logic: decay prescaler, command choice and clamped accumulator update
   always_comb begin
      inc_s    = 1'b0;
      dec_s    = 1'b0;
      fast_s   = 1'b0;
      setval_s = 1'b0;
      decay_s  = 1'b0;
      amount_s = ZERO_S;
      presc_s  = presc_r;
      acc_s    = acc_r;

      if (!bus.decay_en) begin
         presc_s = PRE_ZERO;
      end else if (bus.tick) begin
         if (presc_r == PRE_LAST) begin
            decay_s = 1'b1;
            presc_s = PRE_ZERO;
         end else begin
            presc_s = presc_r + PRE_ONE;
         end
      end else begin
         presc_s = presc_r;
      end

      delta_s = (bus.gain_req  ? ONE_S  : ZERO_S)
              + (bus.gain_fast ? FAST_S : ZERO_S)
              - (bus.loss_req  ? ONE_S  : ZERO_S)
              - (bus.loss_fast ? FAST_S : ZERO_S)
              - (decay_s       ? ONE_S  : ZERO_S);

      if (state_r != ST_GAP) begin
         if (acc_ext_s >= FAST_S) begin
            inc_s    = 1'b1;
            fast_s   = 1'b1;
            amount_s = FAST_S;
         end else if (acc_ext_s <= -FAST_S) begin
            dec_s    = 1'b1;
            fast_s   = 1'b1;
            amount_s = -FAST_S;
         end else if (acc_ext_s > ZERO_S) begin
            inc_s    = 1'b1;
            amount_s = ONE_S;
         end else if (acc_ext_s < ZERO_S) begin
            dec_s    = 1'b1;
            amount_s = -ONE_S;
         end else begin
            amount_s = ZERO_S;
         end
      end else begin
         amount_s = ZERO_S;
      end

      // Wide sum so opposing bursts saturate instead of wrapping
      sum_s = acc_ext_s + delta_s - amount_s;
      if (sum_s > ACC_MAX_S) begin
         acc_s = ACC_MAX_S[ACC_W-1:0];
      end else if (sum_s < ACC_MIN_S) begin
         acc_s = ACC_MIN_S[ACC_W-1:0];
      end else begin
         acc_s = sum_s[ACC_W-1:0];
      end

      if (bus.set_req) begin
         setval_s = 1'b1;
         inc_s    = 1'b0;
         dec_s    = 1'b0;
         fast_s   = 1'b0;
         acc_s    = ACC_ZERO;
         presc_s  = PRE_ZERO;
      end else begin
         setval_s = 1'b0;
      end
   end

   // Registered datapath and command outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r    <= ACC_ZERO;
         presc_r  <= PRE_ZERO;
         inc_r    <= 1'b0;
         dec_r    <= 1'b0;
         fast_r   <= 1'b0;
         setval_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         acc_r    <= acc_s;
         presc_r  <= presc_s;
         inc_r    <= inc_s;
         dec_r    <= dec_s;
         fast_r   <= fast_s;
         setval_r <= setval_s;
         busy_r   <= busy_s;
      end
   end

   assign bus.inc     = inc_r;
   assign bus.dec     = dec_r;
   assign bus.fast    = fast_r;
   assign bus.setval  = setval_r;
   assign bus.pending = acc_r;
   assign bus.busy    = busy_r;
endmodule
